// File: rtl/iter_shifter_pkg.sv
// Shared types for the iterative x86 shift/rotate unit: operation codes,
// FLAGS bit positions and the controller state encoding.
package iter_shifter_pkg;

    localparam int ShiftOp_t_BITS = 3;

    typedef enum logic [ShiftOp_t_BITS-1:0] {
        SHL = 3'd0,
        SHR = 3'd1,
        SAR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4,
        RCL = 3'd5,
        RCR = 3'd6
    } ShiftOp_t;

    localparam int CF_IDX = 0;
    localparam int PF_IDX = 2;
    localparam int AF_IDX = 4;
    localparam int ZF_IDX = 6;
    localparam int SF_IDX = 7;
    localparam int OF_IDX = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ShiftState_t;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// Combinational single-bit shift/rotate step; in byte mode only value[7:0]
// takes part and the upper bits of the result are forced to zero.
module shift_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  ShiftOp_t         op_i,
    input  logic             is8_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             cf_i,
    output logic [WIDTH-1:0] value_o,
    output logic             cf_o
);

    logic             msb;
    logic             lsb;
    logic             fillBit;
    logic [WIDTH-1:0] shifted;

    // Right-moving ops leave a hole at the operand msb; fillBit plugs it.
    always_comb begin
        msb     = is8_i ? value_i[7] : value_i[WIDTH-1];
        lsb     = value_i[0];
        shifted = value_i;
        fillBit = 1'b0;
        cf_o    = cf_i;
        case (op_i)
            SHL: begin
                shifted = value_i << 1;
                cf_o    = msb;
            end
            ROL: begin
                shifted = (value_i << 1) | WIDTH'(msb);
                cf_o    = msb;
            end
            RCL: begin
                shifted = (value_i << 1) | WIDTH'(cf_i);
                cf_o    = msb;
            end
            SHR: begin
                shifted = value_i >> 1;
                cf_o    = lsb;
            end
            SAR: begin
                shifted = value_i >> 1;
                fillBit = msb;
                cf_o    = lsb;
            end
            ROR: begin
                shifted = value_i >> 1;
                fillBit = lsb;
                cf_o    = lsb;
            end
            RCR: begin
                shifted = value_i >> 1;
                fillBit = cf_i;
                cf_o    = lsb;
            end
            default: begin
                shifted = value_i;
                cf_o    = cf_i;
            end
        endcase

        value_o = shifted;
        if (is8_i) begin
            value_o[7]         = shifted[7] | fillBit;
            value_o[WIDTH-1:8] = '0;
        end else begin
            value_o[WIDTH-1]   = shifted[WIDTH-1] | fillBit;
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle x86 shift/rotate unit, one bit position per clock.
// Define SHIFT_COUNT_MASK_EN to mask the count to 5 bits at acceptance (80186 style).
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  ShiftOp_t               op,
    input  logic                   is_8_bit,
    input  logic [WIDTH-1:0]       a,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [15:0]            flags_in,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       out,
    output logic [15:0]            flags_out
);

    ShiftState_t            state_q,     state_d;
    logic [WIDTH-1:0]       value_q,     value_d;
    logic                   cf_q,        cf_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    ShiftOp_t               op_q,        op_d;
    logic                   is8_q,       is8_d;
    logic                   origMsb_q,   origMsb_d;
    logic [15:0]            flagsIn_q,   flagsIn_d;
    logic [WIDTH-1:0]       out_q,       out_d;
    logic [15:0]            flagsOut_q,  flagsOut_d;

    logic [COUNT_WIDTH-1:0] effCount;
    logic [WIDTH-1:0]       aMasked;
    logic [WIDTH-1:0]       stepValue;
    logic                   stepCf;
    logic [15:0]            finalFlags;
    logic                   resMsb;
    logic                   resMsb1;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op_i   (op_q),
        .is8_i  (is8_q),
        .value_i(value_q),
        .cf_i   (cf_q),
        .value_o(stepValue),
        .cf_o   (stepCf)
    );

    always_comb begin
`ifdef SHIFT_COUNT_MASK_EN
        effCount = count & COUNT_WIDTH'(5'h1F);
`else
        effCount = count;
`endif
        aMasked = is_8_bit ? WIDTH'(a[7:0]) : a;
    end

    // Flags are formed from the value/CF the final step produces, so they
    // are ready to register on the same edge that enters DONE.
    always_comb begin
        resMsb     = is8_q ? stepValue[7] : stepValue[WIDTH-1];
        resMsb1    = is8_q ? stepValue[6] : stepValue[WIDTH-2];
        finalFlags = flagsIn_q;
        finalFlags[CF_IDX] = stepCf;
        case (op_q)
            SHL, ROL, RCL: finalFlags[OF_IDX] = resMsb ^ stepCf;
            SHR:           finalFlags[OF_IDX] = origMsb_q;
            SAR:           finalFlags[OF_IDX] = 1'b0;
            default:       finalFlags[OF_IDX] = resMsb ^ resMsb1;
        endcase
        if (op_q == SHL || op_q == SHR || op_q == SAR) begin
            finalFlags[PF_IDX] = ~^stepValue[7:0];
            finalFlags[SF_IDX] = resMsb;
            finalFlags[ZF_IDX] = (stepValue == '0);
        end
    end

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        cf_d        = cf_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        is8_d       = is8_q;
        origMsb_d   = origMsb_q;
        flagsIn_d   = flagsIn_q;
        out_d       = out_q;
        flagsOut_d  = flagsOut_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d        = op;
                    is8_d       = is_8_bit;
                    value_d     = aMasked;
                    cf_d        = flags_in[CF_IDX];
                    flagsIn_d   = flags_in;
                    remaining_d = effCount;
                    origMsb_d   = is_8_bit ? a[7] : a[WIDTH-1];
                    if (effCount == '0) begin
                        out_d      = aMasked;
                        flagsOut_d = flags_in;
                        state_d    = DONE;
                    end else begin
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                value_d     = stepValue;
                cf_d        = stepCf;
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == COUNT_WIDTH'(1)) begin
                    out_d      = stepValue;
                    flagsOut_d = finalFlags;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            value_q     <= '0;
            cf_q        <= 1'b0;
            remaining_q <= '0;
            op_q        <= SHL;
            is8_q       <= 1'b0;
            origMsb_q   <= 1'b0;
            flagsIn_q   <= '0;
            out_q       <= '0;
            flagsOut_q  <= '0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            cf_q        <= cf_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            is8_q       <= is8_d;
            origMsb_q   <= origMsb_d;
            flagsIn_q   <= flagsIn_d;
            out_q       <= out_d;
            flagsOut_q  <= flagsOut_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign out       = out_q;
    assign flags_out = flagsOut_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: closed-form arithmetic model checked every
// cycle, plus literal expectations per vector (honours SHIFT_COUNT_MASK_EN).
module tb_iter_shifter;
    import iter_shifter_pkg::*;

    localparam int WIDTH = 16;
    localparam int CW    = 8;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    ShiftOp_t          opSig   = SHL;
    logic              is8Sig  = 1'b0;
    logic [WIDTH-1:0]  aSig    = '0;
    logic [CW-1:0]     cntSig  = '0;
    logic [15:0]       finSig  = '0;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  outSig;
    logic [15:0]       foutSig;

    int vectors     = 0;
    int miscompares = 0;
    int cycleCnt    = 0;
    int acceptCycle = 0;
    int lat;

    ShiftOp_t          lastOp;
    logic              lastB8;
    logic [WIDTH-1:0]  lastA;
    logic [CW-1:0]     lastCnt;
    logic [15:0]       lastFin;

    iter_shifter #(
        .WIDTH(WIDTH),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (opSig),
        .is_8_bit (is8Sig),
        .a        (aSig),
        .count    (cntSig),
        .flags_in (finSig),
        .busy     (busy),
        .done     (done),
        .out      (outSig),
        .flags_out(foutSig)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Closed-form result: shifts as wide arithmetic, rotates as modular rotations.
    function automatic void modelOp(input ShiftOp_t o, input logic b8, input logic [WIDTH-1:0] av,
                                    input int cIn, input logic [15:0] fin,
                                    output logic [WIDTH-1:0] ro, output logic [15:0] rf);
        int n, m, c, k;
        logic [63:0] mask, mask1, x, t, y, z, r;
        logic cf, of, msb, msb1;
        n = b8 ? 8 : WIDTH;
        c = cIn;
`ifdef SHIFT_COUNT_MASK_EN
        c = c % 32;
`endif
        mask  = (64'd1 << n) - 64'd1;
        x     = 64'(av) & mask;
        if (c == 0) begin
            ro = WIDTH'(x);
            rf = fin;
            return;
        end
        m     = n + 1;
        mask1 = (64'd1 << m) - 64'd1;
        y     = x | (64'(fin[CF_IDX]) << n);
        r  = '0;
        cf = 1'b0;
        case (o)
            SHL: begin t = x << c; cf = t[n]; r = t & mask; end
            SHR: begin r = x >> c; t = (x << 1) >> c; cf = t[0]; end
            SAR: begin
                t  = x[n-1] ? (x | ~mask) : x;
                r  = ($signed(t) >>> c) & mask;
                z  = $signed(t << 1) >>> c;
                cf = z[0];
            end
            ROL: begin k = c % n; r = ((x << k) | (x >> (n - k))) & mask; cf = r[0]; end
            ROR: begin k = c % n; r = ((x >> k) | (x << (n - k))) & mask; cf = r[n-1]; end
            RCL: begin k = c % m; z = ((y << k) | (y >> (m - k))) & mask1; r = z & mask; cf = z[n]; end
            default: begin k = c % m; z = ((y >> k) | (y << (m - k))) & mask1; r = z & mask; cf = z[n]; end
        endcase
        msb  = r[n-1];
        msb1 = r[n-2];
        case (o)
            SHL, ROL, RCL: of = msb ^ cf;
            SHR:           of = x[n-1];
            SAR:           of = 1'b0;
            default:       of = msb ^ msb1;
        endcase
        rf = fin;
        rf[CF_IDX] = cf;
        rf[OF_IDX] = of;
        if (o == SHL || o == SHR || o == SAR) begin
            rf[PF_IDX] = ~^r[7:0];
            rf[SF_IDX] = msb;
            rf[ZF_IDX] = (r == 64'd0);
        end
        ro = WIDTH'(r);
    endfunction

    int               mState  = 0;
    int               mRemain = 0;
    logic [WIDTH-1:0] heldOut = '0, pendOut;
    logic [15:0]      heldFlags = '0, pendFlags;

    // Per-cycle compare against the model's view of timing and held results.
    always @(posedge clk) begin
        int c;
        #1;
        if (!reset_n) begin
            mState    = 0;
            heldOut   = '0;
            heldFlags = '0;
        end else if (mState == 0) begin
            if (start) begin
                c = int'(cntSig);
`ifdef SHIFT_COUNT_MASK_EN
                c = c % 32;
`endif
                modelOp(opSig, is8Sig, aSig, int'(cntSig), finSig, pendOut, pendFlags);
                if (c == 0) begin
                    mState    = 2;
                    heldOut   = pendOut;
                    heldFlags = pendFlags;
                end else begin
                    mState  = 1;
                    mRemain = c;
                end
            end
        end else if (mState == 1) begin
            mRemain = mRemain - 1;
            if (mRemain == 0) begin
                mState    = 2;
                heldOut   = pendOut;
                heldFlags = pendFlags;
            end
        end else begin
            mState = 0;
        end
        vectors++;
        if (busy !== (mState == 1) || done !== (mState == 2) ||
            outSig !== heldOut || foutSig !== heldFlags) begin
            miscompares++;
            $display("[TB] FAIL cycle_%0d: got busy=%b done=%b out=%h flags=%h, expected busy=%b done=%b out=%h flags=%h",
                     cycleCnt, busy, done, outSig, foutSig, mState == 1, mState == 2, heldOut, heldFlags);
        end
    end

    task automatic applyStimulus(input ShiftOp_t o, input logic b8, input logic [WIDTH-1:0] av,
                                 input logic [CW-1:0] c, input logic [15:0] f);
        @(negedge clk);
        opSig  = o;  is8Sig = b8;  aSig = av;  cntSig = c;  finSig = f;
        lastOp = o;  lastB8 = b8;  lastA = av; lastCnt = c; lastFin = f;
        start  = 1'b1;
        acceptCycle = cycleCnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int latency);
        latency = -1;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                latency = cycleCnt - acceptCycle;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string name, input int expLat, input int gotLat,
                               input logic [WIDTH-1:0] expOut, input logic [15:0] expFlags);
        logic [WIDTH-1:0] mOut;
        logic [15:0]      mFlags;
        modelOp(lastOp, lastB8, lastA, int'(lastCnt), lastFin, mOut, mFlags);
        vectors += 5;
        if (gotLat != expLat) begin
            miscompares++;
            $display("[TB] FAIL %s latency: got %0d, expected %0d", name, gotLat, expLat);
        end
        if (outSig !== expOut) begin
            miscompares++;
            $display("[TB] FAIL %s out: got %h, expected %h", name, outSig, expOut);
        end
        if (foutSig !== expFlags) begin
            miscompares++;
            $display("[TB] FAIL %s flags: got %h, expected %h", name, foutSig, expFlags);
        end
        if (mOut !== expOut) begin
            miscompares++;
            $display("[TB] FAIL %s model_out: got %h, expected %h", name, mOut, expOut);
        end
        if (mFlags !== expFlags) begin
            miscompares++;
            $display("[TB] FAIL %s model_flags: got %h, expected %h", name, mFlags, expFlags);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(SHL, 1'b0, 16'h8001, 8'd1, 16'h0000);
        waitDone(lat); checkOutput("shl_c1", 2, lat, 16'h0002, 16'h0801);

        applyStimulus(RCL, 1'b1, 16'h0080, 8'd9, 16'h0000);
        waitDone(lat); checkOutput("rcl_byte_c9", 10, lat, 16'h0080, 16'h0800);

        applyStimulus(SAR, 1'b0, 16'h8000, 8'd15, 16'h0000);
        waitDone(lat); checkOutput("sar_c15", 16, lat, 16'hFFFF, 16'h0084);

        applyStimulus(ROR, 1'b1, 16'h0001, 8'd1, 16'h0000);
        waitDone(lat); checkOutput("ror_byte_c1", 2, lat, 16'h0080, 16'h0801);

        applyStimulus(SHL, 1'b0, 16'h1234, 8'd0, 16'h0895);
        waitDone(lat); checkOutput("count0_word", 1, lat, 16'h1234, 16'h0895);

        applyStimulus(SHL, 1'b1, 16'h1234, 8'd0, 16'h0895);
        waitDone(lat); checkOutput("count0_byte", 1, lat, 16'h0034, 16'h0895);

        applyStimulus(SHR, 1'b0, 16'hFFFF, 8'd33, 16'h0000);
        waitDone(lat);
`ifdef SHIFT_COUNT_MASK_EN
        checkOutput("shr_c33", 2, lat, 16'h7FFF, 16'h0805);
`else
        checkOutput("shr_c33", 34, lat, 16'h0000, 16'h0844);
`endif

        applyStimulus(ROL, 1'b0, 16'h8001, 8'd4, 16'h00D5);
        waitDone(lat); checkOutput("rol_c4_keepflags", 5, lat, 16'h0018, 16'h00D4);

        applyStimulus(RCR, 1'b0, 16'h0001, 8'd17, 16'h0001);
        waitDone(lat); checkOutput("rcr_c17_restore", 18, lat, 16'h0001, 16'h0001);

        applyStimulus(SHL, 1'b1, 16'h12FF, 8'd8, 16'h0000);
        waitDone(lat); checkOutput("shl_byte_c8", 9, lat, 16'h0000, 16'h0845);

        applyStimulus(SAR, 1'b1, 16'h0081, 8'd3, 16'h0010);
        waitDone(lat); checkOutput("sar_byte_c3", 4, lat, 16'h00F0, 16'h0094);

        // A second start while running must not disturb the first operation.
        applyStimulus(SHL, 1'b0, 16'h0003, 8'd5, 16'h0000);
        repeat (2) @(negedge clk);
        opSig = ROR; aSig = 16'hFFFF; cntSig = 8'd1; finSig = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(lat); checkOutput("start_in_run", 6, lat, 16'h0060, 16'h0004);

        // Reset mid-operation discards it; a fresh start then completes.
        applyStimulus(SHL, 1'b0, 16'h00FF, 8'd10, 16'h0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || outSig !== 16'h0000 || foutSig !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_run: got busy=%b done=%b out=%h flags=%h, expected 0 0 0000 0000",
                     busy, done, outSig, foutSig);
        end
        reset_n = 1'b1;
        repeat (12) @(negedge clk);

        applyStimulus(SHL, 1'b0, 16'h00FF, 8'd4, 16'h0000);
        waitDone(lat); checkOutput("after_reset", 5, lat, 16'h0FF0, 16'h0004);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
